// File: rtl/tdes_pkg.sv
// rtl/tdes_pkg.sv - shared types and constants for the triple-DES block packer
package tdes_pkg;

    localparam int BLOCK_W         = 64;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam logic [0:BLOCK_W-1] PAD_BLOCK = 64'h0808080808080808;

endpackage

// File: rtl/tdes_pad_fill.sv
// rtl/tdes_pad_fill.sv - pads byte slots n..7 of a partial block
// TDES_PACKER_PKCS7_EN selects PKCS#7 fill; otherwise slots are zero-filled.
module tdes_pad_fill
    import tdes_pkg::*;
(
    input  logic [0:BLOCK_W-1] blk_i,
    input  logic [3:0]         n_i,
    output logic [0:BLOCK_W-1] blk_o
);

    logic [BYTE_W-1:0] pad_byte;

`ifdef TDES_PACKER_PKCS7_EN
    assign pad_byte = {4'd0, 4'd8 - n_i};
`else
    assign pad_byte = '0;
`endif

    always_comb begin
        blk_o = blk_i;
        for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
            if (k >= int'(n_i)) begin
                blk_o[k*BYTE_W +: BYTE_W] = pad_byte;
            end
        end
    end

endmodule

// File: rtl/tdes_block_packer.sv
// rtl/tdes_block_packer.sv - packs a framed byte stream into padded 64-bit big-endian blocks
// TDES_PACKER_PKCS7_EN enables PKCS#7 padding with an extra pad block on aligned messages.
module tdes_block_packer
    import tdes_pkg::*;
#(
    parameter int BLKCNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          byte_i,
    input  logic                byte_valid_i,
    input  logic                byte_last_i,
    output logic                byte_ready_o,
    output logic [0:63]         data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                start_o,
    output logic [BLKCNT_W-1:0] blocks_o,
    output logic                msg_done_o
);

    state_e                state_q, state_d;
    logic [0:BLOCK_W-1]    data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  start_q, start_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic                  pend_pad_q, pend_pad_d;
    logic                  msg_done_q, msg_done_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [BLKCNT_W-1:0]   blocks_q, blocks_d;

    logic                  byte_fire, blk_fire;
    logic [0:BLOCK_W-1]    fill_blk, padded_blk;
    logic [3:0]            n_bytes;

    assign byte_fire = byte_valid_i & byte_ready_q;
    assign blk_fire  = valid_q & ready_i;
    assign n_bytes   = {1'b0, cnt_q} + 4'd1;

    always_comb begin
        fill_blk = data_q;
        fill_blk[{cnt_q, 3'b000} +: BYTE_W] = byte_i;
    end

    tdes_pad_fill u_pad_fill (
        .blk_i (fill_blk),
        .n_i   (n_bytes),
        .blk_o (padded_blk)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            data_q       <= '0;
            valid_q      <= 1'b0;
            byte_ready_q <= 1'b0;
            start_q      <= 1'b0;
            first_q      <= 1'b1;
            last_q       <= 1'b0;
            pend_pad_q   <= 1'b0;
            msg_done_q   <= 1'b0;
            cnt_q        <= '0;
            blocks_q     <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            byte_ready_q <= byte_ready_d;
            start_q      <= start_d;
            first_q      <= first_d;
            last_q       <= last_d;
            pend_pad_q   <= pend_pad_d;
            msg_done_q   <= msg_done_d;
            cnt_q        <= cnt_d;
            blocks_q     <= blocks_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        valid_d      = valid_q;
        byte_ready_d = byte_ready_q;
        start_d      = start_q;
        first_d      = first_q;
        last_d       = last_q;
        pend_pad_d   = pend_pad_q;
        msg_done_d   = 1'b0;
        cnt_d        = cnt_q;
        blocks_d     = blocks_q;

        case (state_q)
            IDLE: begin
                state_d      = FILL;
                byte_ready_d = 1'b1;
            end
            FILL: begin
                if (byte_fire) begin
                    data_d = fill_blk;
                    cnt_d  = cnt_q + 3'd1;
                    if (byte_last_i || cnt_q == 3'd7) begin
                        if (byte_last_i) begin
                            data_d = padded_blk;
                            last_d = 1'b1;
`ifdef TDES_PACKER_PKCS7_EN
                            pend_pad_d = (n_bytes == 4'd8);
`endif
                        end
                        state_d      = SEND;
                        valid_d      = 1'b1;
                        byte_ready_d = 1'b0;
                        start_d      = first_q;
                        cnt_d        = '0;
                    end
                end
            end
            SEND: begin
                if (blk_fire) begin
                    blocks_d = first_q ? {{(BLKCNT_W-1){1'b0}}, 1'b1}
                                       : blocks_q + {{(BLKCNT_W-1){1'b0}}, 1'b1};
                    start_d  = 1'b0;
                    if (pend_pad_q) begin
                        // Aligned message: the pad block becomes the final block.
                        data_d     = PAD_BLOCK;
                        pend_pad_d = 1'b0;
                        first_d    = 1'b0;
                    end else begin
                        state_d      = FILL;
                        valid_d      = 1'b0;
                        byte_ready_d = 1'b1;
                        cnt_d        = '0;
                        if (last_q) begin
                            first_d    = 1'b1;
                            last_d     = 1'b0;
                            msg_done_d = 1'b1;
                        end else begin
                            first_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign byte_ready_o = byte_ready_q;
    assign start_o      = start_q;
    assign blocks_o     = blocks_q;
    assign msg_done_o   = msg_done_q;

endmodule

// File: tb/tb_tdes_block_packer.sv
// tb/tb_tdes_block_packer.sv - scoreboard bench for tdes_block_packer
module tb_tdes_block_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  byte_i = '0;
    logic        byte_valid_i = 1'b0;
    logic        byte_last_i = 1'b0;
    logic        byte_ready_o;
    logic [0:63] data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        start_o;
    logic [15:0] blocks_o;
    logic        msg_done_o;

    tdes_block_packer #(.BLKCNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_last_i  (byte_last_i),
        .byte_ready_o (byte_ready_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .start_o      (start_o),
        .blocks_o     (blocks_o),
        .msg_done_o   (msg_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        bit          start;
        bit          fin;
        int          idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   ready_mode = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: chop the message into 8-byte blocks, padding the tail.
    task automatic push_model(input logic [7:0] m[$]);
        int n = m.size();
        int nblk = (n + 7) / 8;
        int rem = n % 8;
        logic [7:0] pad;
        exp_t e;
`ifdef TDES_PACKER_PKCS7_EN
        if (rem == 0) nblk++;
        pad = 8'(8 - rem);
`else
        pad = 8'h00;
`endif
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            for (int k = 0; k < 8; k++) begin
                int i = b * 8 + k;
                e.data[63-8*k -: 8] = (i < n) ? m[i] : pad;
            end
            e.start = (b == 0);
            e.fin   = (b == nblk - 1);
            e.idx   = b + 1;
            sb.push_back(e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        int  t = 0;
        bit  done = 0;
        byte_i       = b;
        byte_last_i  = last;
        byte_valid_i = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (byte_ready_o) done = 1;
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 300) begin
                check("byte_accept_timeout", 0, 1);
                done = 1;
            end
        end
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] m[$], input bit gaps);
        push_model(m);
        for (int i = 0; i < m.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_byte(m[i], i == m.size() - 1);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: ready_i = 1'b1;
                1: ready_i = 1'($urandom_range(0, 1));
                default: ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: pops expectations on every block transfer, checks stalls and pulses.
    initial begin
        bit          exp_done = 0;
        bit          chk_blocks = 0;
        int          exp_blocks = 0;
        bit          stalled = 0;
        logic [63:0] held_data = '0;
        bit          held_start = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_done = 0;
                chk_blocks = 0;
                stalled = 0;
                continue;
            end
            check("msg_done", 128'(msg_done_o), 128'(exp_done));
            if (chk_blocks) check("blocks_o", 128'(blocks_o), 128'(exp_blocks));
            exp_done = 0;
            chk_blocks = 0;
            if (stalled)
                check("stall_hold", {valid_o, byte_ready_o, start_o, data_o},
                      {1'b1, 1'b0, held_start, held_data});
            stalled = 0;
            if (valid_o) begin
                if (ready_i) begin
                    if (sb.size() == 0) begin
                        check("unexpected_block", 128'(data_o), 128'h0);
                    end else begin
                        e = sb.pop_front();
                        check("block_data", 128'(data_o), 128'(e.data));
                        check("block_start", 128'(start_o), 128'(e.start));
                        exp_done = e.fin;
                        exp_blocks = e.idx;
                        chk_blocks = 1;
                    end
                end else begin
                    stalled = 1;
                    held_data = data_o;
                    held_start = start_o;
                end
            end
        end
    end

    initial begin
        logic [7:0] m[$];
        int t;
        reset = 1'b0;
        #12;
        check("reset_outputs", {data_o, valid_o, start_o, byte_ready_o, blocks_o, msg_done_o}, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("idle_byte_ready", 128'(byte_ready_o), 128'h0);
        @(posedge clk);
        #1;
        check("fill_byte_ready", 128'(byte_ready_o), 128'h1);

        ready_mode = 0;
        m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_msg(m, 0);
        m = '{8'hAA, 8'hBB, 8'hCC};
        send_msg(m, 0);
        m = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
              8'h08, 8'h09, 8'h0A, 8'h0B};
        send_msg(m, 0);
        m = '{8'h5A};
        send_msg(m, 0);

        // Backpressure with the next message's bytes presented during SEND.
        ready_mode = 2;
        fork
            begin
                logic [7:0] a[$];
                logic [7:0] b[$];
                a = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
                b = '{8'h30, 8'h31, 8'h32};
                send_msg(a, 0);
                send_msg(b, 0);
            end
            begin
                t = 0;
                while (!valid_o && t < 100) begin
                    @(posedge clk);
                    t++;
                end
                if (t >= 100) check("valid_timeout", 0, 1);
                repeat (5) @(posedge clk);
                ready_mode = 0;
            end
        join

        // Reset in the middle of a partial block.
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i), 0);
        #2;
        reset = 1'b0;
        #1;
        check("midfill_reset", {data_o, valid_o, start_o, byte_ready_o, blocks_o, msg_done_o}, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        send_msg(m, 0);

        ready_mode = 1;
        for (int j = 0; j < 15; j++) begin
            int len = int'($urandom_range(1, 20));
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            send_msg(m, 1);
        end

        ready_mode = 0;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("drain_empty", 128'(sb.size()), 128'h0);
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdes_block_packer.md
Name: tdes_block_packer

Overview:
Upstream feeder for the CBC triple-DES core. Accepts a byte stream framed into messages by a last flag and packs it into 64-bit big-endian blocks. Pads the final block and presents blocks on a valid/ready handshake that connects directly to the core's data_i/valid_i/ready_o/start_i. Also reports per-message block count and a message-done pulse.

Parameters:
BLKCNT_W, 16, width of the per-message block counter blocks_o; the counter wraps modulo 2^BLKCNT_W.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
byte_i  in  8  input byte
byte_valid_i  in  1  byte_i is valid
byte_last_i  in  1  byte_i is the final byte of the message
byte_ready_o  out  1  packer accepts a byte this cycle
data_o  out  [0:63]  packed block; first byte of the block is on data_o[0:7]
valid_o  out  1  data_o is valid
ready_i  in  1  downstream core ready
start_o  out  1  data_o is the first block of a message (new IV/chain); qualified by valid_o
blocks_o  out  BLKCNT_W  blocks accepted downstream in the current or just-finished message
msg_done_o  out  1  one-cycle pulse when the final block of a message is accepted

Behaviour:
- Reset values (async, reset==0): state IDLE, data_o=0, valid_o=0, start_o=0, byte_ready_o=0, blocks_o=0, msg_done_o=0, byte count=0, pend_pad=0, first=1.
- Byte transfer: occurs on a rising clk when byte_valid_i && byte_ready_o.
- Block transfer: occurs on a rising clk when valid_o && ready_i.
- All outputs are registered.
- IDLE -> FILL unconditionally on the first clk after reset release. byte_ready_o becomes 1 in that cycle.
- FILL: byte_ready_o=1 and valid_o=0. Each accepted byte is written to byte slot cnt (slot k occupies data_o[8k:8k+7]) and cnt increments.
  - cnt==7 accepted without last: go to SEND, valid_o=1, byte_ready_o=0.
  - last accepted with n=cnt+1<8 bytes: fill slots n..7 with padding (see Optional Feature), then go to SEND.
  - last accepted with n==8: go to SEND; set pend_pad when the pad feature is enabled.
- SEND: valid_o=1, byte_ready_o=0. data_o and start_o are held stable until accepted. byte_valid_i is ignored.
  - On block transfer with pend_pad=1: load the pad block 0x0808080808080808, clear pend_pad, stay in SEND.
  - On block transfer otherwise: valid_o=0, cnt=0, return to FILL (byte_ready_o=1 the next cycle).
- Throughput: at best one block per 9 cycles (8 fill cycles plus 1 handshake). Input and output do not overlap.
- start_o = first-flag, driven alongside valid_o.
  - first is cleared on transfer of the first block.
  - first is set again when the final block of a message transfers.
- blocks_o is cleared to 0 on the first block transfer of a message, then incremented (resulting value 1); +1 on each later transfer. It holds its value after message end until the next message's first transfer.
- msg_done_o = 1 for exactly the cycle after the final block's transfer, i.e. the block carrying last/padding, or the pad block when one is appended.
- ready_i high while valid_o is low has no effect. valid_o never drops without a transfer.
- Reset asserted mid-fill or mid-send: the partial block is discarded and all state returns to reset values. The next message starts with start_o=1.
- Zero-length messages are not supported: every message carries at least one byte.

Optional Feature:
Macro TDES_PACKER_PKCS7_EN.
- Defined: PKCS#7 padding. Slots n..7 are filled with the value 8-n. A message that ends aligned to 8 bytes gets an extra block of 0x08 bytes, and pend_pad is used.
- Undefined: slots n..7 are zero-filled. No extra block is appended, and pend_pad is constant 0 and removed by synthesis.

Decomposition:
- Shared package tdes_pkg: BLOCK_W=64, BYTE_W=8, BYTES_PER_BLOCK=8, state encoding (IDLE, FILL, SEND), PAD_BLOCK constant 64'h0808080808080808.
- One natural sub-module, tdes_pad_fill: combinational; takes the partial block and count n and returns the padded block. It holds the macro-dependent fill logic.

Test Plan:
1. PKCS7_EN; bytes 01..08 with last on 08, ready_i=1 -> blocks 0102030405060708 (start_o=1), then 0808080808080808 (start_o=0). msg_done_o pulses once after the second block; blocks_o=2.
2. Bytes AA,BB,CC with last on CC -> single block AABBCC0505050505 with start_o=1, msg_done_o pulse, blocks_o=1. With the macro undefined -> AABBCC0000000000.
3. Backpressure: after 8 bytes, hold ready_i=0 for 5 cycles -> valid_o=1 and data_o/start_o stable throughout, byte_ready_o=0, no byte consumed. The block transfers on the first ready_i=1 cycle.
4. Back-to-back messages: 12 bytes 00..0B with last on 0B, then 1 byte 5A with last (PKCS7_EN) -> 0001020304050607 (start=1), 08090A0B04040404 (start=0), 5A07070707070707 (start=1). msg_done_o pulses twice; blocks_o reads 2, then 1.
5. Assert reset after 5 bytes of a message -> all outputs return to 0 asynchronously. After release, 8 bytes 11..18 with last -> first block 1112131415161718 with start_o=1; no stale bytes appear.
6. Drive byte_valid_i=1 continuously during SEND with ready_i low -> those bytes are not consumed. The first post-SEND byte lands in slot 0 of the next block.
